vga_bounce_gen: RTL and testbench
=================================

Name: vga_bounce_gen

Overview:
Parametrised successor to the fixed 640x480 screensaver core. It combines a generic VGA timing generator (any mode, any sync polarity, any colour depth) with a bouncing-box renderer. The renderer has runtime speed and pause controls, colour cycling on every wall hit, and status pulses. It sits directly under the tile wrapper, which maps its sync and colour outputs to uo_out/uio_out.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync
VSYNC_POL, 0, active level of vsync
BOX_W, 64, box width (pixels)
BOX_H, 32, box height (pixels)
COLOR_W, 4, bits per colour channel

Ports:
clk  input  1  pixel clock, single clock domain
rst_n  input  1  asynchronous active-low reset
pause  input  1  1 = freeze box position at frame updates
speed  input  3  pixels moved per frame per axis; 0 = frozen
pattern_sel  input  1  background select; used only with TEST_PATTERN_EN
hsync  output  1  horizontal sync, registered
vsync  output  1  vertical sync, registered
r  output  COLOR_W  red, registered
g  output  COLOR_W  green, registered
b  output  COLOR_W  blue, registered
display_on  output  1  1 while the pixel on r/g/b is visible
frame_start  output  1  one-cycle pulse, aligned with output pixel (0,0)
bounce  output  1  one-cycle pulse on each frame update that hits at least one wall

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1).
  - hc wraps to 0 at its maximum, and vc advances on that wrap.
  - vc wraps at V_TOTAL-1.
- Sync timing:
  - hsync is active when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC.
  - Active level is set by the *_POL parameter.
- Latency: every output is registered and lags the counter state by exactly 1 cycle.
  - hsync, vsync, colour and display_on all use the same 1-cycle delay.
- Reset (asynchronous, rst_n low), all outputs held:
  - hc=vc=0
  - hsync=!HSYNC_POL, vsync=!VSYNC_POL
  - r=g=b=0, display_on=0, frame_start=0, bounce=0
  - box x=0, y=0, dx=+, dy=+, colour index ci=1
- Release of reset: counting starts on the first rising clk edge with rst_n high. frame_start asserts 1 cycle after the counter is at (0,0).
- Pixel colour:
  - Outside the visible area: r=g=b=0.
  - Inside the box (x<=hc<x+BOX_W and y<=vc<y+BOX_H): palette[ci].
  - Elsewhere in the visible area: background, which is black.
- Palette (3-bit ci):
  - For ci=1..7, each channel is all-ones if its bit is set and 0 otherwise (bit0 -> R, bit1 -> G, bit2 -> B).
  - For ci=0, each channel is MSB-only, i.e. mid-grey.
- Frame update, in the single cycle with hc=H_TOTAL-1 and vc=V_TOTAL-1:
  - speed and pause are sampled only in this cycle; mid-frame changes have no effect.
  - If pause=1 or speed=0: no movement and no bounce.
  - Otherwise, per axis: nx = x +/- speed.
    - Moving + and nx >= H_ACTIVE-BOX_W: set x=H_ACTIVE-BOX_W and flip dx.
    - Moving - and nx <= 0 (signed compare, no underflow): set x=0 and flip dx.
    - The y axis follows the same rule with V_ACTIVE-BOX_H.
  - If either axis flipped: ci increments by 1 (mod 8, so 7 -> 0), and bounce pulses once, 1 cycle later. A corner hit (both axes) gives a single increment and a single pulse.
- Arithmetic: position registers are clog2(H_ACTIVE)+1 and clog2(V_ACTIVE)+1 bits wide, so nx never wraps.
- Parameter constraints: BOX_W <= H_ACTIVE and BOX_H <= V_ACTIVE. Violations are a compile-time error.

Optional Feature:
TEST_PATTERN_EN:
- Defined: when pattern_sel=1, the background is 8 equal vertical bars, with bar k = palette[k], k = hc*8/H_ACTIVE. The box is still drawn on top.
- Undefined: pattern_sel is ignored, the background is always black, and no bar-index logic is present.

Test Plan:
- Reset, then default params: hsync low for hc 656..751 (96 cycles), line 800 cycles, vsync low for lines 490..491, frame 420000 cycles; frame_start period is 420000 cycles.
- speed=7, pause=0 from reset: y reaches 448 at frame update 64 and dy flips, bounce pulses and ci=2. At update 83, x clamps to 576, dx flips and ci=3.
- BOX_W=H_ACTIVE-4, BOX_H=V_ACTIVE-4, speed=4: both axes hit on the first update -> single bounce pulse, ci 1 -> 2.
- pause=1 held across 3 updates -> box pixels at identical coordinates and no bounce. Toggle pause mid-frame -> takes effect only at the next update.
- Assert rst_n low at hc=300, vc=200 -> all outputs at reset values immediately, without waiting for a clock edge. After release, the first frame_start comes 420000 cycles after the previous reference point is irrelevant: it comes 1 cycle after the counter reaches (0,0).
- TEST_PATTERN_EN, pattern_sel=1: pixel (40,300) = palette[0] grey (1000 per channel), pixel (600,300) = palette[7] white; undefined build -> both black.

Source files
------------

// File: rtl/vga_bounce_gen.sv
// rtl/vga_bounce_gen.sv - VGA timing generator with bouncing-box renderer
// Optional bar background via TEST_PATTERN_EN.
module vga_bounce_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int BOX_W     = 64,
    parameter int BOX_H     = 32,
    parameter int COLOR_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pause,
    input  logic [2:0]         speed,
    input  logic               pattern_sel,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               display_on,
    output logic               frame_start,
    output logic               bounce
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACTIVE) + 1;
    localparam int YW      = $clog2(V_ACTIVE) + 1;
    localparam int X_MAX   = H_ACTIVE - BOX_W;
    localparam int Y_MAX   = V_ACTIVE - BOX_H;
    localparam int PIX_W   = 3 * COLOR_W;

    generate
        if (BOX_W > H_ACTIVE || BOX_H > V_ACTIVE) begin : g_bad_box
            $error("vga_bounce_gen: box larger than active area");
        end
    endgenerate

    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic [XW-1:0]   x, x_n;
    logic [YW-1:0]   y, y_n;
    logic            dx, dx_n, dy, dy_n;
    logic [2:0]      ci;
    logic            hit_x, hit_y;
    logic            h_last, v_last, upd, move;
    logic            visible, in_box, hs_act, vs_act;
    logic [PIX_W-1:0] bg, pix;
    int              nx, ny;

    // Channel is all-ones per set bit; index 0 is the mid-grey entry.
    function automatic logic [PIX_W-1:0] palette(input logic [2:0] idx);
        logic [COLOR_W-1:0] mid;
        mid = '0;
        mid[COLOR_W-1] = 1'b1;
        if (idx == 3'd0)
            return {mid, mid, mid};
        return {{COLOR_W{idx[0]}}, {COLOR_W{idx[1]}}, {COLOR_W{idx[2]}}};
    endfunction

    assign h_last = (hc == HC_W'(H_TOTAL - 1));
    assign v_last = (vc == VC_W'(V_TOTAL - 1));
    assign upd    = h_last && v_last;
    assign move   = upd && !pause && (speed != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (h_last) begin
            hc <= '0;
            vc <= v_last ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    assign visible = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
    assign hs_act  = (int'(hc) >= H_ACTIVE + H_FP) && (int'(hc) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_act  = (int'(vc) >= V_ACTIVE + V_FP) && (int'(vc) < V_ACTIVE + V_FP + V_SYNC);
    assign in_box  = (int'(hc) >= int'(x)) && (int'(hc) < int'(x) + BOX_W) &&
                     (int'(vc) >= int'(y)) && (int'(vc) < int'(y) + BOX_H);

`ifdef TEST_PATTERN_EN
    logic [2:0] bar;
    assign bar = 3'((int'(hc) * 8) / H_ACTIVE);
    assign bg  = pattern_sel ? palette(bar) : '0;
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
    assign bg = '0;
`endif

    assign pix = !visible ? '0 : (in_box ? palette(ci) : bg);

    // Signed int arithmetic so a step past either wall never wraps.
    always_comb begin
        x_n   = x;
        dx_n  = dx;
        hit_x = 1'b0;
        nx    = 0;
        if (move) begin
            nx = dx ? int'(x) + int'(speed) : int'(x) - int'(speed);
            if (dx && nx >= X_MAX) begin
                x_n   = XW'(X_MAX);
                dx_n  = 1'b0;
                hit_x = 1'b1;
            end else if (!dx && nx <= 0) begin
                x_n   = '0;
                dx_n  = 1'b1;
                hit_x = 1'b1;
            end else begin
                x_n = XW'(nx);
            end
        end
    end

    always_comb begin
        y_n   = y;
        dy_n  = dy;
        hit_y = 1'b0;
        ny    = 0;
        if (move) begin
            ny = dy ? int'(y) + int'(speed) : int'(y) - int'(speed);
            if (dy && ny >= Y_MAX) begin
                y_n   = YW'(Y_MAX);
                dy_n  = 1'b0;
                hit_y = 1'b1;
            end else if (!dy && ny <= 0) begin
                y_n   = '0;
                dy_n  = 1'b1;
                hit_y = 1'b1;
            end else begin
                y_n = YW'(ny);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= '0;
            y      <= '0;
            dx     <= 1'b1;
            dy     <= 1'b1;
            ci     <= 3'd1;
            bounce <= 1'b0;
        end else begin
            x      <= x_n;
            y      <= y_n;
            dx     <= dx_n;
            dy     <= dy_n;
            ci     <= ci + {2'b00, hit_x | hit_y};
            bounce <= hit_x | hit_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            display_on  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            {r, g, b}   <= pix;
            display_on  <= visible;
            frame_start <= (hc == '0) && (vc == '0);
        end
    end

endmodule

// File: tb/tb_vga_bounce_gen.sv
// tb/tb_vga_bounce_gen.sv - scoreboard bench for vga_bounce_gen in a small video mode
module tb_vga_bounce_gen;

    localparam int HA = 16, HT = 24, VA = 12, BW = 6, BH = 3;

    logic       clk = 1'b0;
    logic       rst_n, pause, pattern_sel;
    logic [2:0] speed;
    logic       hsync, vsync, display_on, frame_start, bounce;
    logic [3:0] r, g, b;

    vga_bounce_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .BOX_W(BW), .BOX_H(BH), .COLOR_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pause(pause), .speed(speed),
        .pattern_sel(pattern_sel), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b), .display_on(display_on),
        .frame_start(frame_start), .bounce(bounce)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         x;
        int         y;
        logic [11:0] col;
        int         bnc;
    } exp_t;
    exp_t sbq[$];

    // Frame k shows the box after update k; stimulus for update k is applied during frame k-1.
    int          exp_x [13] = '{0, 3, 6, 9, 9, 9, 9, 10, 5, 0, 7, 10, 8};
    int          exp_y [13] = '{0, 3, 6, 9, 9, 9, 9, 8, 3, 0, 7, 9, 7};
    logic [11:0] exp_c [13] = '{12'hF00, 12'hF00, 12'hF00, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0,
                                12'hFF0, 12'hFF0, 12'h00F, 12'h00F, 12'hF0F, 12'hF0F};
    int          exp_b [13] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0};
    int          spd   [13] = '{0, 3, 3, 3, 3, 3, 0, 1, 5, 5, 7, 7, 2};
    int          pse   [13] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 2000);
        check("frame_start wait", {31'd0, frame_start}, 32'd1);
    endtask

    int          oh, ov, npix, derr, bcnt, bframe, fx, fy, fidx;
    bit          in_frame, found, vis;
    logic [11:0] fcol, pix;
    exp_t        e;

    initial begin : monitor
        in_frame = 0;
        bcnt     = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 0;
                bcnt     = 0;
                fidx     = -1;
            end else begin
                if (bounce === 1'b1) bcnt++;
                if (frame_start === 1'b1) begin
                    if (in_frame && sbq.size() > 0) begin
                        e = sbq.pop_front();
                        check($sformatf("frame%0d box x", fidx), fx, e.x);
                        check($sformatf("frame%0d box y", fidx), fy, e.y);
                        check($sformatf("frame%0d colour", fidx), {20'd0, fcol}, {20'd0, e.col});
                        check($sformatf("frame%0d box pixels", fidx), npix, BW * BH);
                        check($sformatf("frame%0d bounce pulses", fidx), bframe, e.bnc);
                        check($sformatf("frame%0d raster errors", fidx), derr, 0);
                    end
                    in_frame = 1;
                    oh = 0; ov = 0; npix = 0; derr = 0; found = 0;
                    fx = -1; fy = -1; fcol = '0;
                    bframe = bcnt;
                    bcnt   = 0;
                    fidx++;
                end
                if (in_frame) begin
                    vis = (oh < HA) && (ov < VA);
                    pix = {r, g, b};
                    if (display_on !== vis) derr++;
                    if (!vis && pix !== 12'h000) derr++;
                    if (pix !== 12'h000) begin
                        npix++;
                        if (!found) begin
                            found = 1;
                            fx = oh; fy = ov; fcol = pix;
                        end else if (pix !== fcol) begin
                            derr++;
                        end
                    end
                    oh++;
                    if (oh == HT) begin
                        oh = 0;
                        ov++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int hs_first, hs_low, hs_falls, vs_first, vs_low, fs_extra, n;
        logic hs_prev;
        rst_n = 1'b0;
        pause = 1'b0;
        speed = 3'd0;
`ifdef TEST_PATTERN_EN
        pattern_sel = 1'b0;
`else
        pattern_sel = 1'b1;
`endif
        repeat (2) @(negedge clk);
        check("reset outputs", {15'd0, hsync, vsync, r, g, b, display_on, frame_start, bounce}, 32'h18000);
        rst_n = 1'b1;

        wait_fs();
        hs_first = -1; vs_first = -1; hs_low = 0; vs_low = 0; hs_falls = 0; fs_extra = 0;
        hs_prev = 1'b1;
        for (int t = 0; t < 384; t++) begin
            if (t > 0) @(negedge clk);
            if (t > 0 && frame_start === 1'b1) fs_extra++;
            if (hsync === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = t;
                if (hs_prev === 1'b1) hs_falls++;
            end
            if (vsync === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = t;
            end
            hs_prev = hsync;
        end
        @(negedge clk);
        check("hsync first active pixel", hs_first, 18);
        check("hsync active cycles per frame", hs_low, 48);
        check("hsync pulses per frame", hs_falls, 16);
        check("vsync first active cycle", vs_first, 312);
        check("vsync active cycles", vs_low, 48);
        check("extra frame_start", fs_extra, 0);
        check("frame period", {31'd0, frame_start}, 32'd1);

        @(negedge clk);
        check("box pixel before reset", {20'd0, r, g, b}, 32'hF00);
        #2 rst_n = 1'b0;
        #1 check("async reset outputs", {15'd0, hsync, vsync, r, g, b, display_on, frame_start, bounce}, 32'h18000);

        speed = 3'(spd[1]);
        pause = pse[1][0];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sbq.push_back('{exp_x[0], exp_y[0], exp_c[0], exp_b[0]});
        check("frame_start held in reset", {31'd0, frame_start}, 32'd0);
        @(negedge clk);
        check("first frame_start", {31'd0, frame_start}, 32'd1);
        check("pixel 0,0 after reset", {20'd0, r, g, b}, 32'hF00);

        for (int k = 1; k <= 12; k++) begin
            if (k > 1) wait_fs();
            repeat (40) @(negedge clk);
            speed = 3'(spd[k]);
            pause = pse[k][0];
            sbq.push_back('{exp_x[k], exp_y[k], exp_c[k], exp_b[k]});
            if (k == 8) begin
                pause = 1'b1;
                repeat (100) @(negedge clk);
                pause = 1'b0;
            end
        end

        n = 0;
        while (sbq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
